// File: rtl/cbc_dec_chain.sv
// CBC decrypt chaining around a decipher core: m_valid one cycle after dec_done, one block in flight, s_ready low until output taken.
// Optional CBC_DEC_CHAIN_BYPASS_EN adds a per-block bypass input selecting raw (ECB) core output.
`timescale 1ns/1ps
module cbc_dec_chain #(
    parameter int BLK_S = 128,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iv_load,
    input  logic [BLK_S-1:0] iv_in,
    input  logic [BLK_S-1:0] s_blk,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             dec_en,
    output logic [BLK_S-1:0] dec_ct,
    input  logic [BLK_S-1:0] dec_pt,
    input  logic             dec_done,
    output logic [BLK_S-1:0] m_blk,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] blk_cnt,
`ifdef CBC_DEC_CHAIN_BYPASS_EN
    input  logic             bypass,
`endif
    output logic             seq_err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        HOLD = 2'b10,
        BAD  = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_capture;
    logic             w_release;
    logic             w_flush;
    logic             w_iv_load;
    logic [BLK_S-1:0] w_pt_out;

    logic [BLK_S-1:0] r_chain;
    logic [BLK_S-1:0] r_cur_ct;
    logic [BLK_S-1:0] r_dec_ct;
    logic [BLK_S-1:0] r_m_blk;
    logic [CNT_W-1:0] r_blk_cnt;
    logic             r_dec_en;
    logic             r_m_valid;
    logic             r_seq_err;
`ifdef CBC_DEC_CHAIN_BYPASS_EN
    logic             r_byp;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            IDLE: begin
                if (s_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (dec_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_flush     = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_iv_load = iv_load && (r_state == IDLE);

`ifdef CBC_DEC_CHAIN_BYPASS_EN
    assign w_pt_out = r_byp ? dec_pt : (dec_pt ^ r_chain);
`else
    assign w_pt_out = dec_pt ^ r_chain;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_chain   <= '0;
            r_cur_ct  <= '0;
            r_dec_ct  <= '0;
            r_m_blk   <= '0;
            r_blk_cnt <= '0;
            r_dec_en  <= 1'b0;
            r_m_valid <= 1'b0;
            r_seq_err <= 1'b0;
`ifdef CBC_DEC_CHAIN_BYPASS_EN
            r_byp     <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_dec_en <= w_accept;
            // IV load and acceptance may coincide; the accepted block chains on the new IV
            if (w_iv_load) begin
                r_chain <= iv_in;
            end
            if (w_accept) begin
                r_cur_ct <= s_blk;
                r_dec_ct <= s_blk;
`ifdef CBC_DEC_CHAIN_BYPASS_EN
                r_byp    <= bypass;
`endif
            end
            if (w_capture) begin
                r_m_blk   <= w_pt_out;
                r_chain   <= r_cur_ct;
                r_m_valid <= 1'b1;
            end
            if (w_release || w_flush) begin
                r_m_valid <= 1'b0;
            end
            if (w_iv_load) begin
                r_blk_cnt <= '0;
            end else if (w_release) begin
                r_blk_cnt <= r_blk_cnt + 1'b1;
            end
            if (dec_done && (r_state != BUSY)) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    // Held low through the reset cycle so nothing is accepted while resetting
    assign s_ready = (r_state == IDLE) && !reset;
    assign dec_en  = r_dec_en;
    assign dec_ct  = r_dec_ct;
    assign m_blk   = r_m_blk;
    assign m_valid = r_m_valid;
    assign blk_cnt = r_blk_cnt;
    assign seq_err = r_seq_err;

endmodule
